// File: rtl/light_show_pkg.sv
// Shared types and default sizing for the RGB light-show sequencer.
package light_show_pkg;

    localparam int unsigned DEF_CLK_DIV_SLOW = 50_000;
    localparam int unsigned DEF_CLK_DIV_FAST = 12_500;
    localparam int unsigned DEF_DUTY_W       = 8;
    localparam int unsigned DEF_FADE_INC     = 4;
    localparam int unsigned NUM_CH           = 3;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_BLINK_ON  = 3'd1,
        ST_BLINK_OFF = 3'd2,
        ST_FADE_UP   = 3'd3,
        ST_FADE_DOWN = 3'd4
    } state_t;

endpackage

// File: rtl/light_pattern_sequencer_pwm_channel.sv
// One PWM output: duty shadow reloaded at period end, registered compare.
module pwm_channel #(
    parameter int unsigned DUTY_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] duty,
    input  logic              load,
    input  logic [DUTY_W-1:0] pwm_cnt,
    output logic              pwm
);

    logic [DUTY_W-1:0] shadow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            pwm    <= 1'b0;
        end else begin
            if (load) begin
                shadow <= duty;
            end
            pwm <= (pwm_cnt < shadow);
        end
    end

endmodule

// File: rtl/light_pattern_sequencer.sv
// Step prescaler, blink/fade pattern FSM and shared PWM counter driving three LED channels.
module light_pattern_sequencer
    import light_show_pkg::*;
#(
    parameter int unsigned CLK_DIV_SLOW = DEF_CLK_DIV_SLOW,
    parameter int unsigned CLK_DIV_FAST = DEF_CLK_DIV_FAST,
    parameter int unsigned DUTY_W       = DEF_DUTY_W,
    parameter int unsigned FADE_INC     = DEF_FADE_INC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        color_sel,
    input  logic              speed_fast,
    input  logic              pattern_sel,
    output logic [2:0]        pwm_out,
    output logic              step_tick,
    output logic [DUTY_W-1:0] level
);

    localparam int unsigned MAX_LVL = (1 << DUTY_W) - 1;
    localparam int unsigned DIV_MAX = (CLK_DIV_SLOW > CLK_DIV_FAST) ? CLK_DIV_SLOW : CLK_DIV_FAST;
    localparam int unsigned CNT_W   = $clog2(DIV_MAX);
    localparam int unsigned EXT_W   = DUTY_W + 1;

    localparam logic [DUTY_W-1:0] LVL_MAX   = DUTY_W'(MAX_LVL);
    localparam logic [DUTY_W-1:0] PWM_LAST  = DUTY_W'(MAX_LVL - 1);
    localparam logic [CNT_W-1:0]  SLOW_LAST = CNT_W'(CLK_DIV_SLOW - 1);
    localparam logic [CNT_W-1:0]  FAST_LAST = CNT_W'(CLK_DIV_FAST - 1);
    localparam logic [EXT_W-1:0]  INC_EXT   = EXT_W'(FADE_INC);
    localparam logic [EXT_W-1:0]  MAX_EXT   = EXT_W'(MAX_LVL);

    state_t            state, state_nxt;
    logic [DUTY_W-1:0] level_nxt;
    logic [CNT_W-1:0]  div_cnt, div_nxt, div_last;
    logic              speed_q, pattern_q;
    logic              speed_edge, pattern_edge, restart, tick_raw, tick;
    logic [EXT_W-1:0]  up_sum, dn_diff;
    logic [DUTY_W-1:0] up_lvl, dn_lvl;
    logic [DUTY_W-1:0] pwm_cnt;
    logic              pwm_load;
    logic [DUTY_W-1:0] duty [NUM_CH];

    // Edge detection, tick qualification and prescaler next value
    always_comb begin
        div_last     = speed_fast ? FAST_LAST : SLOW_LAST;
        speed_edge   = speed_fast ^ speed_q;
        pattern_edge = pattern_sel ^ pattern_q;
        restart      = pattern_edge && (state != ST_OFF) && (color_sel != 3'b000);
        tick_raw     = (div_cnt == div_last);
        tick         = tick_raw && !speed_edge && !restart;
        if (speed_edge || restart || tick_raw) begin
            div_nxt = '0;
        end else begin
            div_nxt = div_cnt + CNT_W'(1);
        end
    end

    assign step_tick = tick;

    // Clamped fade arithmetic; a set top bit on the difference means it went below zero
    always_comb begin
        up_sum  = EXT_W'(level) + INC_EXT;
        dn_diff = EXT_W'(level) - INC_EXT;
        up_lvl  = (up_sum > MAX_EXT) ? LVL_MAX : up_sum[DUTY_W-1:0];
        dn_lvl  = dn_diff[DUTY_W] ? '0 : dn_diff[DUTY_W-1:0];
    end

    // Pattern FSM next state and level
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        if (color_sel == 3'b000) begin
            state_nxt = ST_OFF;
            level_nxt = '0;
        end else if ((state == ST_OFF) || restart) begin
            if (pattern_sel) begin
                state_nxt = ST_FADE_UP;
                level_nxt = '0;
            end else begin
                state_nxt = ST_BLINK_ON;
                level_nxt = LVL_MAX;
            end
        end else if (tick) begin
            case (state)
                ST_BLINK_ON: begin
                    state_nxt = ST_BLINK_OFF;
                    level_nxt = '0;
                end
                ST_BLINK_OFF: begin
                    state_nxt = ST_BLINK_ON;
                    level_nxt = LVL_MAX;
                end
                ST_FADE_UP: begin
                    level_nxt = up_lvl;
                    if (up_lvl == LVL_MAX) state_nxt = ST_FADE_DOWN;
                end
                ST_FADE_DOWN: begin
                    level_nxt = dn_lvl;
                    if (dn_lvl == '0) state_nxt = ST_FADE_UP;
                end
                default: begin
                    state_nxt = ST_OFF;
                    level_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_OFF;
            level     <= '0;
            div_cnt   <= '0;
            speed_q   <= 1'b0;
            pattern_q <= 1'b0;
            pwm_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            div_cnt   <= div_nxt;
            speed_q   <= speed_fast;
            pattern_q <= pattern_sel;
            pwm_cnt   <= pwm_load ? '0 : pwm_cnt + DUTY_W'(1);
        end
    end

    assign pwm_load = (pwm_cnt == PWM_LAST);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            duty[i] = color_sel[i] ? level : '0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .duty    (duty[g]),
            .load    (pwm_load),
            .pwm_cnt (pwm_cnt),
            .pwm     (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_light_pattern_sequencer.sv
// Self-checking bench: directed tables and sequences plus randomized run against a behavioural model.
module tb_light_pattern_sequencer;

    localparam int MAXL = 15;
    localparam int INC  = 4;
    localparam int SLOW = 8;
    localparam int FAST = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] color_sel = 3'b000;
    logic       speed_fast = 1'b0;
    logic       pattern_sel = 1'b0;
    logic [2:0] pwm_out;
    logic       step_tick;
    logic [3:0] level;

    int n_checks = 0;
    int n_errors = 0;

    light_pattern_sequencer #(
        .CLK_DIV_SLOW (SLOW),
        .CLK_DIV_FAST (FAST),
        .DUTY_W       (4),
        .FADE_INC     (INC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .color_sel   (color_sel),
        .speed_fast  (speed_fast),
        .pattern_sel (pattern_sel),
        .pwm_out     (pwm_out),
        .step_tick   (step_tick),
        .level       (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         do_rst;
        logic [2:0] color;
        logic       pattern;
        int         exp_level;
        int         exp_gap;
    } vec_t;

    typedef enum {M_OFF, M_BON, M_BOFF, M_UP, M_DN} mstate_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Lands 2 time units after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [2:0] c, input logic p);
        reset = 1'b0;
        color_sel = c;
        pattern_sel = p;
        speed_fast = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_level", 32'(level), 0);
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_tick", 32'(step_tick), 0);
        reset = 1'b1;
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (step_tick !== 1'b1 && n < 40) begin
            next_cycle();
            n++;
        end
        next_cycle();
        n++;
    endtask

    // From cycle 0 after release with color_sel=0: idle output, tick every SLOW cycles
    task automatic off_run(input int ncyc);
        for (int c = 0; c <= ncyc; c++) begin
            check("off_tick", 32'(step_tick), ((c % SLOW) == SLOW - 1) ? 1 : 0);
            check("off_level", 32'(level), 0);
            check("off_pwm", 32'(pwm_out), 0);
            if (c < ncyc) next_cycle();
        end
    endtask

    // Behavioural reference model state
    mstate_t m_state;
    int      m_div, m_level, m_pcnt;
    int      m_shadow [3];
    bit      m_pwm [3];
    bit      m_sq, m_pq;

    task automatic model_init();
        m_state = M_OFF;
        m_div = 0;
        m_level = 0;
        m_pcnt = 0;
        m_sq = 0;
        m_pq = 0;
        for (int i = 0; i < 3; i++) begin
            m_shadow[i] = 0;
            m_pwm[i] = 0;
        end
    endtask

    function automatic int entry_level(input bit pat);
        return pat ? 0 : MAXL;
    endfunction

    // Evaluates the spec rules for one clock with the present inputs; returns the step_tick expected now
    task automatic model_step(output bit exp_tick);
        int  period;
        bit  sp_edge, pt_edge, rst_pat, last;
        period  = speed_fast ? FAST : SLOW;
        sp_edge = (speed_fast != m_sq);
        pt_edge = (pattern_sel != m_pq);
        rst_pat = pt_edge && (m_state != M_OFF) && (color_sel != 0);
        last    = (m_div == period - 1);
        exp_tick = last && !sp_edge && !rst_pat;

        for (int i = 0; i < 3; i++) begin
            m_pwm[i] = (m_pcnt < m_shadow[i]);
            if (m_pcnt == MAXL - 1) m_shadow[i] = color_sel[i] ? m_level : 0;
        end
        m_pcnt = (m_pcnt + 1) % MAXL;

        m_div = (sp_edge || rst_pat || last) ? 0 : m_div + 1;

        if (color_sel == 0) begin
            m_state = M_OFF;
            m_level = 0;
        end else if (m_state == M_OFF || rst_pat) begin
            m_state = pattern_sel ? M_UP : M_BON;
            m_level = entry_level(pattern_sel);
        end else if (exp_tick) begin
            if (m_state == M_BON) begin
                m_state = M_BOFF;
                m_level = 0;
            end else if (m_state == M_BOFF) begin
                m_state = M_BON;
                m_level = MAXL;
            end else if (m_state == M_UP) begin
                m_level = (m_level + INC > MAXL) ? MAXL : m_level + INC;
                if (m_level == MAXL) m_state = M_DN;
            end else begin
                m_level = (m_level - INC < 0) ? 0 : m_level - INC;
                if (m_level == 0) m_state = M_UP;
            end
        end
        m_sq = speed_fast;
        m_pq = pattern_sel;
    endtask

    vec_t vecs[$];

    initial begin
        int gap, hi, found;
        bit et;
        int exp_t[5];
        int exp_l[5];

        vecs.push_back('{1, 3'b101, 1'b0, 0, 8});
        vecs.push_back('{0, 3'b101, 1'b0, 15, 8});
        vecs.push_back('{0, 3'b101, 1'b0, 0, 8});
        vecs.push_back('{0, 3'b101, 1'b0, 15, 8});
        vecs.push_back('{1, 3'b010, 1'b1, 4, 8});
        vecs.push_back('{0, 3'b010, 1'b1, 8, 8});
        vecs.push_back('{0, 3'b010, 1'b1, 12, 8});
        vecs.push_back('{0, 3'b010, 1'b1, 15, 8});
        vecs.push_back('{0, 3'b010, 1'b1, 11, 8});
        vecs.push_back('{0, 3'b010, 1'b1, 7, 8});
        vecs.push_back('{0, 3'b010, 1'b1, 3, 8});
        vecs.push_back('{0, 3'b010, 1'b1, 0, 8});
        vecs.push_back('{0, 3'b010, 1'b1, 4, 8});

        // Reset and idle OFF
        do_reset(3'b000, 1'b0);
        off_run(24);

        // Blink and fade level sequences per tick
        foreach (vecs[k]) begin
            if (vecs[k].do_rst) do_reset(vecs[k].color, vecs[k].pattern);
            color_sel = vecs[k].color;
            pattern_sel = vecs[k].pattern;
            wait_tick(gap);
            check("vec_gap", 32'(gap), 32'(vecs[k].exp_gap));
            check("vec_level", 32'(level), 32'(vecs[k].exp_level));
        end

        // Blink: unused green stays dark, red and blue identical
        do_reset(3'b101, 1'b0);
        hi = 0;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            hi += int'(pwm_out[1]);
            if (pwm_out[0] !== pwm_out[2]) found++;
            next_cycle();
        end
        check("blink_green_dark", 32'(hi), 0);
        check("blink_rb_match", 32'(found), 0);

        // Fade: shadow loaded with level 8 at cycle 149 gives 8/15 duty over cycles 151..165
        do_reset(3'b010, 1'b1);
        repeat (149) next_cycle();
        check("fade_lvl149", 32'(level), 8);
        repeat (2) next_cycle();
        hi = 0;
        found = 0;
        for (int c = 0; c < 15; c++) begin
            hi += int'(pwm_out[1]);
            found += int'(pwm_out[0]) + int'(pwm_out[2]);
            next_cycle();
        end
        check("fade_duty8", 32'(hi), 8);
        check("fade_rb_dark", 32'(found), 0);

        // Speed switch at div_cnt=5
        exp_t = '{0, 0, 1, 0, 1};
        exp_l = '{15, 15, 15, 0, 0};
        do_reset(3'b001, 1'b0);
        repeat (5) next_cycle();
        speed_fast = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("spd_tick", 32'(step_tick), 32'(exp_t[c]));
            check("spd_level", 32'(level), 32'(exp_l[c]));
            next_cycle();
        end
        check("spd_level_end", 32'(level), 15);

        // Pattern change, OFF priority over tick, tick discarded on pattern edge
        do_reset(3'b010, 1'b1);
        repeat (26) next_cycle();
        check("pc_level12", 32'(level), 12);
        pattern_sel = 1'b0;
        #1;
        check("pc_edge_tick", 32'(step_tick), 0);
        next_cycle();
        check("pc_blink_on", 32'(level), 15);
        repeat (7) next_cycle();
        check("pc_tick34", 32'(step_tick), 1);
        next_cycle();
        check("pc_blink_off", 32'(level), 0);
        repeat (7) next_cycle();
        color_sel = 3'b000;
        #1;
        check("pc_tick42", 32'(step_tick), 1);
        next_cycle();
        check("pc_off_prio", 32'(level), 0);
        color_sel = 3'b010;
        next_cycle();
        next_cycle();
        check("pc_exit_off", 32'(level), 15);
        repeat (5) next_cycle();
        pattern_sel = 1'b1;
        #1;
        check("pc_tick_discard", 32'(step_tick), 0);
        next_cycle();
        check("pc_fade_entry", 32'(level), 0);
        repeat (7) next_cycle();
        check("pc_tick_after", 32'(step_tick), 1);
        next_cycle();
        check("pc_fade_first", 32'(level), 4);

        // Asynchronous reset while all channels high
        do_reset(3'b111, 1'b1);
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (pwm_out === 3'b111) found = 1;
            else next_cycle();
        end
        check("ar_found_111", 32'(found), 1);
        #1;
        reset = 1'b0;
        #1;
        check("ar_pwm", 32'(pwm_out), 0);
        check("ar_level", 32'(level), 0);
        color_sel = 3'b000;
        pattern_sel = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        off_run(16);

        // Randomized run against the reference model
        do_reset(3'b000, 1'b0);
        model_init();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) color_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) pattern_sel = ~pattern_sel;
            if ($urandom_range(0, 49) == 0) speed_fast = ~speed_fast;
            #1;
            model_step(et);
            check("rnd_tick", 32'(step_tick), 32'(et));
            next_cycle();
            check("rnd_level", 32'(level), 32'(m_level));
            check("rnd_pwm", 32'(pwm_out), 32'({m_pwm[2], m_pwm[1], m_pwm[0]}));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/light_pattern_sequencer.md
# light_pattern_sequencer

Drives the RGB light show from the three debounced switch levels: color select, speed and pattern. A step-rate prescaler clocks a small pattern FSM that produces a brightness level for blink or triangle-fade patterns. Three glitch-free PWM channels turn that level into `pwm_out`. The block sits directly after the switch debouncers and drives the LED pins.

## Interface
- `CLK_DIV_SLOW`, default 50_000: clk cycles per pattern step when `speed_fast`=0 (≥2)
- `CLK_DIV_FAST`, default 12_500: clk cycles per pattern step when `speed_fast`=1 (≥2)
- `DUTY_W`, default 8: level/duty width; MAX = 2^DUTY_W−1
- `FADE_INC`, default 4: level change per fade step (1..MAX)
- `clk`  in  1  system clock, single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `color_sel`  in  3  debounced channel enables, bit0=R, bit1=G, bit2=B
- `speed_fast`  in  1  debounced speed select
- `pattern_sel`  in  1  debounced pattern select: 0=blink, 1=fade
- `pwm_out`  out  3  registered PWM outputs, bit order as `color_sel`
- `step_tick`  out  1  one-cycle pulse per pattern step
- `level`  out  DUTY_W  current brightness level, for observability

## Operation
- **Prescaler**
  - `div_cnt` counts 0..DIV−1, where DIV is chosen by `speed_fast`.
  - `step_tick`=1 in the cycle `div_cnt`==DIV−1; `div_cnt` then wraps to 0.
  - A change of `speed_fast` (edge vs. registered copy) loads `div_cnt`=0 with no tick in that cycle.
- **FSM states:** OFF, BLINK_ON, BLINK_OFF, FADE_UP, FADE_DOWN.
- **OFF**
  - Entered from any state when `color_sel`==0; sets `level`=0.
  - Exit when `color_sel`≠0: go to BLINK_ON if `pattern_sel`=0, else FADE_UP with `level`=0.
- **Blink**
  - On each tick, BLINK_ON↔BLINK_OFF.
  - `level`=MAX in BLINK_ON and 0 in BLINK_OFF; it updates in the same cycle as the state change.
- **Fade**
  - Arithmetic is done at DUTY_W+1 bits with clamping.
  - FADE_UP: on tick, `level`←min(`level`+FADE_INC, MAX); if the result ==MAX, go to FADE_DOWN.
  - FADE_DOWN: on tick, `level`←max(`level`−FADE_INC, 0); if the result ==0, go to FADE_UP.
- **Pattern change:** an edge on `pattern_sel` while not in OFF restarts the new pattern at its entry state (BLINK_ON or FADE_UP, `level` per that state) and loads `div_cnt`=0.
- **Priority within one cycle:**
  1. `color_sel`==0
  2. `pattern_sel` edge
  3. `speed_fast` edge
  4. tick
- `color_sel` changes between nonzero values do not disturb the FSM. They only change the duty mapping.
- **Duty mapping:** `duty[i]` = `color_sel[i]` ? `level` : 0.
- **PWM**
  - Shared free-running `pwm_cnt` counts 0..MAX−1, so the period is MAX cycles.
  - Each channel holds a shadow duty that is loaded only when `pwm_cnt`==MAX−1.
  - `pwm_out[i]` ← (`pwm_cnt` < shadow[i]).
  - Duty 0 gives constant low; duty MAX gives constant high.

## Timing
- **Reset (asynchronous, active-low) forces:**
  - `pwm_out`=000, `step_tick`=0, `level`=0
  - state OFF, `div_cnt`=0, `pwm_cnt`=0, shadows=0
  - This takes effect immediately, including mid-fade or mid-PWM-period.
- **First tick after reset release:** occurs DIV cycles after release, when `div_cnt` reaches DIV−1.
- **Latency:** `level` changes on the clock edge after `step_tick`. The new duty appears on `pwm_out` from the first cycle of the next PWM period, after the shadow load.
- **Output registration:** `pwm_out` is registered, one cycle after the compare.
- **Simultaneous events:** a tick that coincides with a `pattern_sel` or `speed_fast` edge is discarded.

## Structure
- **Package `light_show_pkg`:**
  - `state_t` enum (OFF, BLINK_ON, BLINK_OFF, FADE_UP, FADE_DOWN)
  - default `CLK_DIV_SLOW` / `CLK_DIV_FAST` / `DUTY_W` constants
- **Sub-module `pwm_channel`:**
  - Contents: shadow register plus compare flop.
  - Inputs: `clk`, `reset`, `duty`, `load`, `pwm_cnt`.
  - Instantiated 3× via generate.
- The prescaler, FSM and shared `pwm_cnt` live in the top of this block.

## Test plan
Parameters for all scenarios: `CLK_DIV_SLOW`=8, `CLK_DIV_FAST`=2, `DUTY_W`=4 (MAX=15), `FADE_INC`=4.
1. **Reset / OFF:** hold `reset`=0 for 5 cycles, then release with `color_sel`=000 → `pwm_out`=000 and `level`=0 forever; `step_tick` pulses every 8 cycles, first pulse 8 cycles after release.
2. **Blink:** `color_sel`=101, `pattern_sel`=0, slow → `level` alternates 15/0 every 8 cycles; `pwm_out[0]` and `pwm_out[2]` are high for whole PWM periods while 15, low while 0; `pwm_out[1]` stays 0.
3. **Fade sequence:** `pattern_sel`=1, `color_sel`=010 → `level` per tick is 0,4,8,12,15,11,7,3,0,4; once the shadow loads with `level`=8, `pwm_out[1]` is high exactly 8 of every 15 cycles.
4. **Speed switch:** toggle `speed_fast` 0→1 when `div_cnt`=5 → no tick that cycle; next `step_tick` exactly 2 cycles later, then every 2.
5. **Pattern change + OFF priority:**
   - Switch `pattern_sel` 1→0 at `level`=12 → next cycle state BLINK_ON, `level`=15.
   - Then assert `color_sel`=000 in the same cycle as a tick → OFF, `level`=0.
6. **Reset mid-fade:** assert `reset`=0 asynchronously while `pwm_out`=111 → `pwm_out`=000 before the next clk edge; after release, the sequence restarts per scenario 1.
